// File: rtl/fb_read_server_if.sv
// fb_read_server_if: request/response bus between the VGA draw logic and the
// framebuffer read server, plus the server's RAM read port.
interface fb_read_server_if #(
    parameter int REQ_AW = 40,
    parameter int MEM_AW = 15
);
    logic              read_bytes;
    logic [REQ_AW-1:0] mem_addr;
    logic [79:0]       input_bytes;
    logic              rd_miss;
    logic              ram_rd_en;
    logic [MEM_AW-1:0] ram_rd_addr;
    logic [31:0]       ram_rd_data;

    // Requester and RAM side
    modport master (
        output read_bytes, mem_addr, ram_rd_data,
        input  input_bytes, rd_miss, ram_rd_en, ram_rd_addr
    );

    // Read server side
    modport slave (
        input  read_bytes, mem_addr, ram_rd_data,
        output input_bytes, rd_miss, ram_rd_en, ram_rd_addr
    );
endinterface

// File: rtl/fb_read_server.sv
// fb_read_server: answers 10-byte framebuffer reads two cycles after the
// request, serving hits from a one-chunk prefetch buffer that is refilled
// with the next predicted chunk (same fb/row, column + STEP mod 256).
// Build macro FB_MISS_COUNT_EN adds the saturating miss_count output.
module fb_read_server #(
    parameter int REQ_AW = 40,
    parameter int MEM_AW = 15,
    parameter int STEP   = 10
) (
    input logic             clk,
    input logic             rst,
    fb_read_server_if.slave bus
`ifdef FB_MISS_COUNT_EN
    ,
    output logic [15:0]     miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    localparam logic [7:0] STEP_B = 8'(STEP);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [16:0]       target_q, tag_q;
    logic [95:0]       line_q;
    logic [79:0]       buf_q, rsp_buf_q, data_q;
    logic              buf_valid_q, boot_q, rsp_pend_q, rsp_hit_q, miss_q;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_addr;

    logic              req, hit, start;
    logic [16:0]       req_addr, predicted, start_addr;
    logic              unused_hi_addr;

    // Only {fb, row, col} is decoded; upper request bits are don't-care.
    assign unused_hi_addr = ^bus.mem_addr[REQ_AW-1:17];
    assign req_addr       = bus.mem_addr[16:0];

    // The release cycle launches the boot prefetch and ignores any request.
    assign req        = bus.read_bytes && !boot_q;
    assign hit        = req && buf_valid_q && (req_addr == tag_q);
    assign predicted  = {tag_q[16:8], tag_q[7:0] + STEP_B};
    assign start      = boot_q || req;
    assign start_addr = boot_q ? '0 : (hit ? predicted : req_addr);

    assign bus.input_bytes = data_q;
    assign bus.rd_miss     = miss_q;
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_addr;

    // Fetch sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and RAM read port; any accepted request restarts the fetch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE: ;
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = MEM_AW'(target_q[16:2]) + MEM_AW'(cnt_q);
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = FETCH;
            cnt_d   = '0;
        end
    end

    // Prefetch buffer, response pipeline and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_q      <= 1'b1;
            target_q    <= '0;
            tag_q       <= '0;
            line_q      <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            rsp_pend_q  <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_buf_q   <= '0;
            data_q      <= '0;
            miss_q      <= 1'b0;
        end else begin
            boot_q <= 1'b0;

            // Words 0..2 arrive during FETCH cycles 1..3; word 3 arrives in LOAD.
            if (state_q == FETCH && cnt_q != 2'd0)
                line_q <= {bus.ram_rd_data, line_q[95:32]};

            // A request in the LOAD cycle wins: its new fetch supersedes this chunk.
            if (state_q == LOAD && !start) begin
                buf_q       <= 80'({bus.ram_rd_data, line_q} >> {target_q[1:0], 3'b000});
                tag_q       <= target_q;
                buf_valid_q <= 1'b1;
            end

            if (start) begin
                target_q    <= start_addr;
                buf_valid_q <= 1'b0;
            end

            rsp_pend_q <= req;
            if (req) begin
                rsp_hit_q <= hit;
                rsp_buf_q <= buf_q;
            end

            if (rsp_pend_q) begin
                data_q <= rsp_hit_q ? rsp_buf_q : '0;
                miss_q <= !rsp_hit_q;
            end else begin
                miss_q <= 1'b0;
            end
        end
    end

`ifdef FB_MISS_COUNT_EN
    // Saturating miss counter, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            miss_count <= '0;
        else if (rsp_pend_q && !rsp_hit_q && miss_count != 16'hFFFF)
            miss_count <= miss_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fb_read_server.sv
// tb_fb_read_server: directed and randomized checks of fb_read_server against
// a timing-rule reference model (prediction address + earliest hit cycle).
module tb_fb_read_server;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic [31:0] mem [0:32767];

    // Reference model state
    logic [16:0] m_tag;
    int          m_valid_from;
    logic [79:0] m_last;
    int          m_misses;

    fb_read_server_if bus ();

`ifdef FB_MISS_COUNT_EN
    logic [15:0] miss_count;
`endif

    fb_read_server dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FB_MISS_COUNT_EN
        ,
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: data valid the cycle after the enable
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ten consecutive bytes at a 17-bit byte address, wrapping the address space
    function automatic logic [79:0] ref_bytes(input logic [16:0] a);
        logic [79:0] r;
        logic [16:0] b;
        logic [31:0] w;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            b = a + 17'(i);
            w = mem[b[16:2]];
            r[i*8 +: 8] = w[b[1:0]*8 +: 8];
        end
        return r;
    endfunction

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("miss_drop", 80'(bus.rd_miss), 80'(0));
                chk("data_hold", bus.input_bytes, m_last);
            end
        end
    endtask

    // One request; checks the restarted fetch address and the N+2 response
    task automatic send(input logic [39:0] a);
        int          n;
        logic        hit;
        logic [79:0] exp;
        logic [16:0] next_tag;
        n   = cyc;
        hit = (n >= m_valid_from) && (a[16:0] == m_tag);
        exp = hit ? ref_bytes(a[16:0]) : '0;
        next_tag = hit ? {a[16:8], a[7:0] + 8'd10} : a[16:0];
        bus.read_bytes = 1'b1;
        bus.mem_addr   = a;
        @(posedge clk);
        #1;
        bus.read_bytes = 1'b0;
        bus.mem_addr   = {$urandom, $urandom};
        chk("fetch_en", 80'(bus.ram_rd_en), 80'(1));
        chk("fetch_addr", 80'(bus.ram_rd_addr), 80'(next_tag[16:2]));
        @(posedge clk);
        #1;
        chk("rsp_data", bus.input_bytes, exp);
        chk("rsp_miss", 80'(bus.rd_miss), 80'(!hit));
        m_tag        = next_tag;
        m_valid_from = n + 6;
        m_last       = exp;
        if (!hit) m_misses++;
    endtask

    // Reset pulse; optionally drives a request in the release cycle (must be ignored)
    task automatic do_reset(input logic with_req);
        int rel;
        rst = 1'b0;
        #1;
        chk("rst_data", bus.input_bytes, '0);
        chk("rst_miss", 80'(bus.rd_miss), 80'(0));
        chk("rst_en", 80'(bus.ram_rd_en), 80'(0));
        chk("rst_addr", 80'(bus.ram_rd_addr), 80'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;
        if (with_req) begin
            bus.read_bytes = 1'b1;
            bus.mem_addr   = 40'h00_0001_2345;
        end
        @(posedge clk);
        #1;
        bus.read_bytes = 1'b0;
        chk("boot_en", 80'(bus.ram_rd_en), 80'(1));
        chk("boot_addr", 80'(bus.ram_rd_addr), 80'(0));
        m_tag        = '0;
        m_valid_from = rel + 6;
        m_last       = '0;
        m_misses     = 0;
        @(posedge clk);
        #1;
        chk("boot_nomiss", 80'(bus.rd_miss), 80'(0));
        chk("boot_data", bus.input_bytes, '0);
    endtask

    initial begin
        logic [39:0] a;
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        rst            = 1'b0;
        bus.read_bytes = 1'b0;
        bus.mem_addr   = '0;
        bus.ram_rd_data = '0;

        // RAM byte value = low byte of its address
        for (int w = 0; w < 32768; w++) begin
            logic [16:0] b;
            b = 17'(w * 4);
            mem[w] = {b[7:0] + 8'd3, b[7:0] + 8'd2, b[7:0] + 8'd1, b[7:0]};
        end

        do_reset(1'b1);
        idle(8);
        send(40'h0);
        chk("t1_const", bus.input_bytes, 80'h09080706050403020100);
        chk("t1_miss", 80'(bus.rd_miss), 80'(0));

        // Row scan of predicted hits through the column wrap
        for (int c = 10; c <= 250; c += 10) begin
            idle(18);
            send(40'(c));
        end
        chk("wrap_const", bus.input_bytes, 80'h03020100FFFEFDFCFBFA);
        idle(18);
        send(40'h4);

        // Off-prediction request misses, repeat hits
        idle(18);
        send(40'h1_0300);
        chk("t3_miss", 80'(bus.rd_miss), 80'(1));
        idle(18);
        send(40'h1_0300);

        // Second request lands in FETCH: both miss, fetch restarts at second target
        idle(18);
        send(40'h0_0520);
        idle(1);
        send(40'h1_7F3C);
        chk("t4_miss", 80'(bus.rd_miss), 80'(1));

        // Request in LOAD cycle misses, one cycle later hits
        idle(18);
        send(40'h0_2210);
        idle(3);
        send(40'h0_2210);
        idle(4);
        send(40'h0_2210);

        // Reset mid-fetch
        idle(18);
        send(40'h0_4444);
        chk("t5_midfetch", 80'(bus.ram_rd_en), 80'(1));
        do_reset(1'b0);
        idle(8);
        send(40'h0);

        // Random RAM contents and randomized request stream
        for (int w = 0; w < 32768; w++) mem[w] = $urandom;
        do_reset(1'b0);
        idle(6);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) < 2)
                a = {23'($urandom), m_tag};
            else
                a = {$urandom, $urandom};
            send(a);
            idle($urandom_range(0, 24));
        end

`ifdef FB_MISS_COUNT_EN
        chk("miss_count", 80'(miss_count), 80'(m_misses));
        bus.read_bytes = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            bus.mem_addr = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        bus.read_bytes = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("miss_sat", 80'(miss_count), 80'(16'hFFFF));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
